// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, count type and window helper for the VGA timing generator.
package vga_pkg;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned H_SYNC_640   = 96;
  localparam int unsigned H_BACK_640   = 48;
  localparam int unsigned H_ACTIVE_640 = 640;
  localparam int unsigned H_FRONT_640  = 16;
  localparam int unsigned V_SYNC_480   = 2;
  localparam int unsigned V_BACK_480   = 33;
  localparam int unsigned V_ACTIVE_480 = 480;
  localparam int unsigned V_FRONT_480  = 10;

  localparam int unsigned H_TOTAL = H_SYNC_640 + H_BACK_640 + H_ACTIVE_640 + H_FRONT_640;
  localparam int unsigned V_TOTAL = V_SYNC_480 + V_BACK_480 + V_ACTIVE_480 + V_FRONT_480;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MODULUS position counter for one screen axis; exposes both the current and next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned MODULUS = H_TOTAL
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output cnt_t count,
  output cnt_t count_next,
  output logic wrap
);

  localparam cnt_t LAST = cnt_t'(MODULUS - 1);

  cnt_t count_q;
  cnt_t count_d;

  always_comb begin
    wrap    = inc && (count_q == LAST);
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; all outputs are registered from the next-state counts.
// Define VGA_FRAME_CNT_EN to build the 8-bit completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = H_SYNC_640,
  parameter int unsigned H_BACK   = H_BACK_640,
  parameter int unsigned H_ACTIVE = H_ACTIVE_640,
  parameter int unsigned H_FRONT  = H_FRONT_640,
  parameter int unsigned V_SYNC   = V_SYNC_480,
  parameter int unsigned V_BACK   = V_BACK_480,
  parameter int unsigned V_ACTIVE = V_ACTIVE_480,
  parameter int unsigned V_FRONT  = V_FRONT_480,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [15:0] h_count,
  output logic [15:0] v_count,
  output logic        h_sync,
  output logic        v_sync,
  output logic        active,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam cnt_t H_SYNC_END = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_END = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_LO   = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t H_ACT_HI   = cnt_t'(H_SYNC + H_BACK + H_ACTIVE);
  localparam cnt_t V_ACT_LO   = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t V_ACT_HI   = cnt_t'(V_SYNC + V_BACK + V_ACTIVE);

  cnt_t h_cnt, h_next, v_cnt, v_next;
  logic h_wrap, v_wrap;

  vga_axis_counter #(.MODULUS(H_TOT)) u_h_counter (
    .clk        (clk),
    .rst        (rst),
    .inc        (ce),
    .count      (h_cnt),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  // The vertical axis only steps on the edge that ends a line.
  vga_axis_counter #(.MODULUS(V_TOT)) u_v_counter (
    .clk        (clk),
    .rst        (rst),
    .inc        (h_wrap),
    .count      (v_cnt),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  logic       h_sync_q, h_sync_d;
  logic       v_sync_q, v_sync_d;
  logic       active_q, active_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    h_sync_d      = (h_next < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    v_sync_d      = (v_next < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    active_d      = in_window(h_next, H_ACT_LO, H_ACT_HI) && in_window(v_next, V_ACT_LO, V_ACT_HI);
    pixel_x_d     = active_d ? 10'(h_next - H_ACT_LO) : '0;
    pixel_y_d     = active_d ? 10'(v_next - V_ACT_LO) : '0;
    // Wraps need an enabled step, so a ce=0 hold at (0,0) cannot re-fire the strobes.
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync_q      <= SYNC_POL;
      v_sync_q      <= SYNC_POL;
      active_q      <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      active_q      <= active_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

  assign h_count     = h_cnt;
  assign v_count     = v_cnt;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign active      = active_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line/sync/window/reset checks and a
// reduced-geometry instance (28x15 total) for whole-frame strobe and frame counter checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: default timing.
  logic        rst_a, ce_a;
  logic [15:0] ha, va;
  logic        hs_a, vs_a, act_a, ls_a, fs_a;
  logic [9:0]  px_a, py_a;
  logic [7:0]  fc_a;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a),
    .h_count(ha), .v_count(va), .h_sync(hs_a), .v_sync(vs_a), .active(act_a),
    .pixel_x(px_a), .pixel_y(py_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  // Instance B: H 4/4/16/4 = 28, V 2/3/8/2 = 15, so one frame is 420 clocks.
  logic        rst_b, ce_b;
  logic [15:0] hb, vb;
  logic        hs_b, vs_b, act_b, ls_b, fs_b;
  logic [9:0]  px_b, py_b;
  logic [7:0]  fc_b;

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(8),  .V_FRONT(2)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b),
    .h_count(hb), .v_count(vb), .h_sync(hs_b), .v_sync(vs_b), .active(act_b),
    .pixel_x(px_b), .pixel_y(py_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; ce_a = 1'b1;
    rst_b = 1'b1; ce_b = 1'b0;
    repeat (3) tick();
    checks++; if (ha !== 16'd0 || va !== 16'd0) begin errors++; $display("FAIL reset_counts got=(%0d,%0d) exp=(0,0)", ha, va); end
    checks++; if (hs_a !== 1'b1 || vs_a !== 1'b1) begin errors++; $display("FAIL reset_sync got=%b%b exp=11", hs_a, vs_a); end
    checks++; if (act_a !== 1'b0 || px_a !== 10'd0 || py_a !== 10'd0) begin errors++; $display("FAIL reset_active got act=%b px=%0d py=%0d exp 0/0/0", act_a, px_a, py_a); end
    checks++; if (ls_a !== 1'b0 || fs_a !== 1'b0 || fc_a !== 8'd0) begin errors++; $display("FAIL reset_strobes got ls=%b fs=%b fc=%0d exp 0/0/0", ls_a, fs_a, fc_a); end
    checks++; if (hb !== 16'd0 || vb !== 16'd0 || hs_b !== 1'b1) begin errors++; $display("FAIL reset_b got=(%0d,%0d) hs=%b exp=(0,0) hs=1", hb, vb, hs_b); end
    $display("test_reset done");
  endtask

  task automatic test_line;
    logic [15:0] eh, ev;
    logic        found;
    rst_a = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      tick();
      eh = 16'(i % 800);
      ev = (i == 800) ? 16'd1 : 16'd0;
      checks++; if (ha !== eh || va !== ev) begin errors++; $display("FAIL line_count i=%0d got=(%0d,%0d) exp=(%0d,%0d)", i, ha, va, eh, ev); end
      checks++; if (ls_a !== (i == 800) || fs_a !== 1'b0) begin errors++; $display("FAIL line_strobe i=%0d got ls=%b fs=%b exp ls=%b fs=0", i, ls_a, fs_a, (i == 800)); end
      checks++; if (hs_a !== (eh < 16'd96)) begin errors++; $display("FAIL h_sync h=%0d got=%b exp=%b", eh, hs_a, (eh < 16'd96)); end
    end
    tick();
    checks++; if (ls_a !== 1'b0 || ha !== 16'd1) begin errors++; $display("FAIL line_strobe_width got ls=%b h=%0d exp ls=0 h=1", ls_a, ha); end
    checks++; if (vs_a !== 1'b1) begin errors++; $display("FAIL v_sync_v1 got=%b exp=1", vs_a); end
    found = 1'b0;
    for (int i = 0; i < 800 && !found; i++) begin
      tick();
      found = (ha == 16'd0);
    end
    checks++; if (!found || va !== 16'd2) begin errors++; $display("FAIL v_line2 found=%b got v=%0d exp v=2", found, va); end
    checks++; if (vs_a !== 1'b0) begin errors++; $display("FAIL v_sync_v2 got=%b exp=0", vs_a); end
    $display("test_line done h=%0d v=%0d", ha, va);
  endtask

  task automatic test_active;
    // From (0,2): 33 lines plus 143 pixels reaches (143,35).
    repeat (33 * 800 + 143) tick();
    checks++; if (ha !== 16'd143 || va !== 16'd35 || act_a !== 1'b0) begin errors++; $display("FAIL act_before got=(%0d,%0d) act=%b exp=(143,35) act=0", ha, va, act_a); end
    tick();
    checks++; if (act_a !== 1'b1 || px_a !== 10'd0 || py_a !== 10'd0) begin errors++; $display("FAIL act_first got act=%b px=%0d py=%0d exp 1/0/0", act_a, px_a, py_a); end
    repeat (639) tick();
    checks++; if (ha !== 16'd783 || act_a !== 1'b1 || px_a !== 10'd639 || py_a !== 10'd0) begin errors++; $display("FAIL act_last_col h=%0d act=%b px=%0d py=%0d exp 783/1/639/0", ha, act_a, px_a, py_a); end
    tick();
    checks++; if (ha !== 16'd784 || act_a !== 1'b0 || px_a !== 10'd0 || py_a !== 10'd0) begin errors++; $display("FAIL act_after h=%0d act=%b px=%0d py=%0d exp 784/0/0/0", ha, act_a, px_a, py_a); end
    $display("test_active done h=%0d v=%0d", ha, va);
  endtask

  task automatic test_ce_toggle;
    logic [15:0] eh, ev;
    eh = ha; ev = va;
    for (int i = 0; i < 40; i++) begin
      ce_a = 1'b1;
      tick();
      eh = (eh == 16'd799) ? 16'd0 : eh + 16'd1;
      if (eh == 16'd0) ev = ev + 16'd1;
      checks++; if (ha !== eh || va !== ev || ls_a !== (eh == 16'd0)) begin errors++; $display("FAIL ce_step i=%0d got=(%0d,%0d) ls=%b exp=(%0d,%0d) ls=%b", i, ha, va, ls_a, eh, ev, (eh == 16'd0)); end
      ce_a = 1'b0;
      tick();
      checks++; if (ha !== eh || ls_a !== 1'b0 || fs_a !== 1'b0) begin errors++; $display("FAIL ce_hold i=%0d got h=%0d ls=%b fs=%b exp h=%0d ls=0 fs=0", i, ha, ls_a, fs_a, eh); end
    end
    ce_a = 1'b1;
    $display("test_ce_toggle done h=%0d v=%0d", ha, va);
  endtask

  task automatic test_reset_mid;
    logic found;
    found = (ha == 16'd400);
    for (int i = 0; i < 800 && !found; i++) begin
      tick();
      found = (ha == 16'd400);
    end
    checks++; if (!found || va !== 16'd36) begin errors++; $display("FAIL mid_reach found=%b got v=%0d exp (400,36)", found, va); end
    rst_a = 1'b1;
    tick();
    checks++; if (ha !== 16'd0 || va !== 16'd0 || ls_a !== 1'b0 || fs_a !== 1'b0) begin errors++; $display("FAIL mid_reset got=(%0d,%0d) ls=%b fs=%b exp=(0,0) 0 0", ha, va, ls_a, fs_a); end
    checks++; if (hs_a !== 1'b1 || vs_a !== 1'b1 || act_a !== 1'b0) begin errors++; $display("FAIL mid_reset_sync got hs=%b vs=%b act=%b exp 1 1 0", hs_a, vs_a, act_a); end
    rst_a = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (ha !== 16'(i) || va !== 16'd0 || fs_a !== 1'b0 || ls_a !== 1'b0) begin errors++; $display("FAIL mid_resume i=%0d got=(%0d,%0d) ls=%b fs=%b exp=(%0d,0) 0 0", i, ha, va, ls_a, fs_a, i); end
    end
    $display("test_reset_mid done h=%0d v=%0d", ha, va);
  endtask

  task automatic test_frame;
    logic [15:0] eh, ev;
    logic        eact;
    logic [9:0]  epx, epy;
    logic [7:0]  efc;
    ce_b = 1'b1;
    rst_b = 1'b0;
    efc = 8'd0;
    for (int i = 1; i <= 421; i++) begin
      tick();
      eh   = 16'(i % 28);
      ev   = 16'((i / 28) % 15);
      eact = (eh >= 16'd8) && (eh < 16'd24) && (ev >= 16'd5) && (ev < 16'd13);
      epx  = eact ? 10'(eh - 16'd8) : 10'd0;
      epy  = eact ? 10'(ev - 16'd5) : 10'd0;
`ifdef VGA_FRAME_CNT_EN
      if (i == 420) efc = 8'd1;
`endif
      checks++; if (hb !== eh || vb !== ev) begin errors++; $display("FAIL frame_count i=%0d got=(%0d,%0d) exp=(%0d,%0d)", i, hb, vb, eh, ev); end
      checks++; if (fs_b !== (i == 420) || ls_b !== (eh == 16'd0)) begin errors++; $display("FAIL frame_strobe i=%0d got fs=%b ls=%b exp fs=%b ls=%b", i, fs_b, ls_b, (i == 420), (eh == 16'd0)); end
      checks++; if (hs_b !== (eh < 16'd4) || vs_b !== (ev < 16'd2)) begin errors++; $display("FAIL frame_sync i=%0d got hs=%b vs=%b exp hs=%b vs=%b", i, hs_b, vs_b, (eh < 16'd4), (ev < 16'd2)); end
      checks++; if (act_b !== eact || px_b !== epx || py_b !== epy) begin errors++; $display("FAIL frame_window i=%0d got act=%b px=%0d py=%0d exp act=%b px=%0d py=%0d", i, act_b, px_b, py_b, eact, epx, epy); end
      checks++; if (fc_b !== efc) begin errors++; $display("FAIL frame_cnt i=%0d got=%0d exp=%0d", i, fc_b, efc); end
    end
    $display("test_frame done fc=%0d", fc_b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; ce_a = 1'b0;
    rst_b = 1'b1; ce_b = 1'b0;
    #1;
    test_reset();
    test_line();
    test_active();
    test_ce_toggle();
    test_reset_mid();
    test_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
